// File: rtl/div3_serial_tx.sv
// MSB-first serializer feeding the mod-3 checker stream (bit / enable / number-end).
// Optional leading-zero suppression: define DIV3_TX_SKIP_LZ_EN.
module div3_serial_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             hold,
    output logic             bit_out,
    output logic             enable_out,
    output logic             num_end_out,
    output logic             busy,
    output logic [CNT_W-1:0] num_count
);

    localparam int unsigned BIT_W = $clog2(WIDTH + 1);
    localparam int unsigned GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_END,
        S_GAP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] load_shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] load_cnt;
    logic [GAP_W-1:0] gap_cnt;

`ifdef DIV3_TX_SKIP_LZ_EN
    // Length = MSB-one index + 1 (zero word sends one bit); align that MSB to the top.
    always_comb begin
        load_cnt = BIT_W'(1);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (din[i]) load_cnt = BIT_W'(i + 1);
        end
        load_shreg = din << (BIT_W'(WIDTH) - load_cnt);
    end
`else
    assign load_cnt   = BIT_W'(WIDTH);
    assign load_shreg = din;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            num_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (din_valid) begin
                        shreg   <= load_shreg;
                        bit_cnt <= load_cnt;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // hold freezes shreg and bit_cnt so the downstream checker state is kept
                    if (!hold) begin
                        shreg   <= {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt - BIT_W'(1);
                        if (bit_cnt == BIT_W'(1)) state <= S_END;
                    end
                end
                S_END: begin
                    num_count <= num_count + CNT_W'(1);
                    if (GAP_CYCLES > 0) begin
                        gap_cnt <= GAP_W'(GAP_CYCLES);
                        state   <= S_GAP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt <= GAP_W'(1)) state <= S_IDLE;
                    else gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stream decode is combinational so hold gates enable_out in the same cycle.
    assign din_ready   = (state == S_IDLE) && !rst;
    assign busy        = (state != S_IDLE);
    assign enable_out  = (state == S_SHIFT) && !hold;
    assign bit_out     = enable_out && shreg[WIDTH-1];
    assign num_end_out = (state == S_END);

endmodule

// File: tb/tb_div3_serial_tx.sv
// Scoreboard bench for div3_serial_tx: expected bits/words queued at handshake,
// checked at negedge against the stream, plus a mod-3 residue model of the checker.
module tb_div3_serial_tx;

    localparam int unsigned GAP = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_valid;
    logic        hold;
    logic        din_ready, bit_out, enable_out, num_end_out, busy;
    logic [15:0] num_count;
    logic        c2_ready, c2_bit, c2_en, c2_end, c2_busy;
    logic [1:0]  c2_count;

    div3_serial_tx #(.WIDTH(8), .GAP_CYCLES(GAP), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .hold(hold), .bit_out(bit_out), .enable_out(enable_out), .num_end_out(num_end_out),
        .busy(busy), .num_count(num_count)
    );

    div3_serial_tx #(.WIDTH(8), .GAP_CYCLES(GAP), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(c2_ready),
        .hold(hold), .bit_out(c2_bit), .enable_out(c2_en), .num_end_out(c2_end),
        .busy(c2_busy), .num_count(c2_count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         exp_bits[$];
    logic [7:0] exp_words[$];
    int         end_cycles[$];
    int         res, nb, last_nb;
    bit         prev_end, last_div, eb;
    logic [7:0] mon_w;

    always @(posedge clk) cyc++;

    function automatic int exp_len(input logic [7:0] w);
`ifdef DIV3_TX_SKIP_LZ_EN
        int n = 1;
        for (int i = 0; i < 8; i++) if (w[i]) n = i + 1;
        return n;
`else
        return 8;
`endif
    endfunction

    task automatic push_word(input logic [7:0] w);
        exp_words.push_back(w);
        for (int i = exp_len(w) - 1; i >= 0; i--) exp_bits.push_back(w[i]);
    endtask

    // Stream monitor: bit order, per-word length, checker residue, invariants
    always @(negedge clk) begin
        if (rst) begin
            res = 0; nb = 0; prev_end = 1'b0;
        end else begin
            checks++;
            if (enable_out && num_end_out) begin
                errors++;
                $display("FAIL inv_en_end: enable_out=1 num_end_out=1, required not both high");
            end
            checks++;
            if (prev_end && num_end_out) begin
                errors++;
                $display("FAIL inv_double_end: num_end_out high two cycles, required single cycle");
            end
            if (enable_out) begin
                checks++;
                if (exp_bits.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit: got bit %0b at cycle %0d, required no bit", bit_out, cyc);
                end else begin
                    eb = exp_bits.pop_front();
                    if (bit_out !== eb) begin
                        errors++;
                        $display("FAIL stream_bit: got %0b, required %0b at cycle %0d", bit_out, eb, cyc);
                    end
                end
                res = (res * 2 + (bit_out ? 1 : 0)) % 3;
                nb++;
            end
            if (num_end_out) begin
                end_cycles.push_back(cyc);
                checks++;
                if (exp_words.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_end: num_end_out at cycle %0d, required none", cyc);
                end else begin
                    mon_w = exp_words.pop_front();
                    if (nb != exp_len(mon_w)) begin
                        errors++;
                        $display("FAIL word_len: got %0d bits for %h, required %0d", nb, mon_w, exp_len(mon_w));
                    end
                    checks++;
                    if ((res == 0) != ((mon_w % 8'd3) == 8'd0)) begin
                        errors++;
                        $display("FAIL div3_result: residue %0d for %h, required divisible=%0b",
                                 res, mon_w, (mon_w % 8'd3) == 8'd0);
                    end
                end
                last_div = (res == 0);
                last_nb  = nb;
                res = 0; nb = 0;
            end
            prev_end = num_end_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; din_valid = 1'b0; hold = 1'b0; din = 8'h00;
        tick(); tick();
        exp_bits.delete(); exp_words.delete(); end_cycles.delete();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [7:0] w, input bit keep_valid);
        bit ok = 1'b0;
        din = w; din_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (din_ready) begin
                push_word(w);
                ok = 1'b1;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: din_ready=0 for 200 cycles, required 1");
        end
        if (!keep_valid) din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            k++;
            tick();
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL idle_timeout: busy=1 after 200 cycles, required 0");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; din_valid = 1'b1; din = 8'hAA; hold = 1'b0;
        #1;
        checks++;
        if ({din_ready, busy, enable_out, num_end_out, bit_out} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready/busy/en/end/bit=%b, required 00000",
                     {din_ready, busy, enable_out, num_end_out, bit_out});
        end
        tick();
        din_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (din_ready !== 1'b1 || busy !== 1'b0 || num_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b count=%0d, required 1 0 0",
                     din_ready, busy, num_count);
        end
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        send_word(8'h0C, 1'b0);
        wait_idle();
        checks++;
        if (num_count !== 16'd1 || last_div !== 1'b1 || end_cycles.size() != 1) begin
            errors++;
            $display("FAIL single_0c: count=%0d div=%0b ends=%0d, required 1 1 1",
                     num_count, last_div, end_cycles.size());
        end
    endtask

    task automatic test_hold();
        apply_reset();
        send_word(8'h0B, 1'b0);
        tick(); tick();
        hold = 1'b1;
        #1;
        checks++;
        if (enable_out !== 1'b0 || bit_out !== 1'b0) begin
            errors++;
            $display("FAIL hold_c1: en=%b bit=%b, required 0 0", enable_out, bit_out);
        end
        tick();
        checks++;
        if (enable_out !== 1'b0 || num_end_out !== 1'b0) begin
            errors++;
            $display("FAIL hold_c2: en=%b end=%b, required 0 0", enable_out, num_end_out);
        end
        tick();
        hold = 1'b0;
        #1;
        checks++;
        if (enable_out !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: en=%b, required 1", enable_out);
        end
        wait_idle();
        checks++;
        if (num_count !== 16'd1 || last_div !== 1'b0) begin
            errors++;
            $display("FAIL hold_0b: count=%0d div=%0b, required 1 0", num_count, last_div);
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        apply_reset();
        send_word(8'h03, 1'b1);
        din = 8'h07;
        while (!din_ready && k < 200) begin
            k++;
            tick();
        end
        checks++;
        if (k != exp_len(8'h03) + 2) begin
            errors++;
            $display("FAIL b2b_ready_low: %0d cycles, required %0d", k, exp_len(8'h03) + 2);
        end
        send_word(8'h07, 1'b0);
        wait_idle();
        checks++;
        if (end_cycles.size() != 2) begin
            errors++;
            $display("FAIL b2b_end_count: %0d strobes, required 2", end_cycles.size());
        end else if (end_cycles[1] - end_cycles[0] != exp_len(8'h07) + 2 + GAP) begin
            errors++;
            $display("FAIL b2b_spacing: %0d cycles, required %0d",
                     end_cycles[1] - end_cycles[0], exp_len(8'h07) + 2 + GAP);
        end
        checks++;
        if (num_count !== 16'd2) begin
            errors++;
            $display("FAIL b2b_count: %0d, required 2", num_count);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send_word(8'h09, 1'b0);
        wait_idle();
        checks++;
        if (num_count !== 16'd1) begin
            errors++;
            $display("FAIL mid_pre_count: %0d, required 1", num_count);
        end
        send_word(8'hFF, 1'b0);
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({din_ready, busy, enable_out, num_end_out, bit_out} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: ready/busy/en/end/bit=%b, required 00000",
                     {din_ready, busy, enable_out, num_end_out, bit_out});
        end
        exp_bits.delete(); exp_words.delete(); end_cycles.delete();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (din_ready !== 1'b1 || num_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_release: ready=%b count=%0d, required 1 0", din_ready, num_count);
        end
        tick(); tick(); tick();
        checks++;
        if (end_cycles.size() != 0) begin
            errors++;
            $display("FAIL mid_no_end: %0d strobes, required 0", end_cycles.size());
        end
    endtask

    task automatic test_skip_lz();
        apply_reset();
        send_word(8'h06, 1'b0);
        wait_idle();
        checks++;
`ifdef DIV3_TX_SKIP_LZ_EN
        if (last_nb != 3) begin
            errors++;
            $display("FAIL lz_06_len: %0d bits, required 3", last_nb);
        end
`else
        if (last_nb != 8) begin
            errors++;
            $display("FAIL lz_06_len: %0d bits, required 8", last_nb);
        end
`endif
        send_word(8'h00, 1'b0);
        wait_idle();
        checks++;
`ifdef DIV3_TX_SKIP_LZ_EN
        if (last_nb != 1 || last_div !== 1'b1) begin
            errors++;
            $display("FAIL lz_00: %0d bits div=%0b, required 1 1", last_nb, last_div);
        end
`else
        if (last_nb != 8 || last_div !== 1'b1) begin
            errors++;
            $display("FAIL lz_00: %0d bits div=%0b, required 8 1", last_nb, last_div);
        end
`endif
    endtask

    task automatic test_cnt_wrap();
        int exp_tbl[5] = '{1, 2, 3, 0, 1};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            send_word(8'($urandom_range(0, 255)), 1'b0);
            wait_idle();
            checks++;
            if (c2_count !== 2'(exp_tbl[i]) || num_count !== 16'(i + 1)) begin
                errors++;
                $display("FAIL cnt_wrap_%0d: c2=%0d wide=%0d, required %0d %0d",
                         i, c2_count, num_count, exp_tbl[i], i + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_skip_lz();
        test_cnt_wrap();
        tick();
        checks++;
        if (exp_bits.size() != 0 || exp_words.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bits %0d words left, required 0 0",
                     exp_bits.size(), exp_words.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
